// File: rtl/commit_arbiter_pkg.sv
// Shared backend types: issue numbers, commit table entries and commit arbiter enums.
package commit_arbiter_pkg;

    localparam int unsigned WIDTH_ISSUE_NO = 8;

    typedef logic [WIDTH_ISSUE_NO-1:0] issue_no_t;

    typedef enum logic {
        COMMIT_SCALAR = 1'b0,
        COMMIT_VECTOR = 1'b1
    } commit_src_t;

    typedef enum logic [1:0] {
        RUN  = 2'd0,
        HOLD = 2'd1,
        ERR  = 2'd2
    } commit_arb_st_t;

    typedef struct packed {
        issue_no_t   no;
        commit_src_t src;
    } commit_entry_t;

endpackage

// File: rtl/commit_arbiter_if.sv
// Commit arbiter bus: two reorder-buffer request streams, the tracker output and status flags.
interface commit_arbiter_if;
    import commit_arbiter_pkg::*;

    logic        req_s;
    issue_no_t   no_s;
    logic        grant_s;
    logic        req_v;
    issue_no_t   no_v;
    logic        grant_v;
    logic        commit_valid;
    issue_no_t   commit_no;
    commit_src_t commit_src;
    logic        commit_ack;
    issue_no_t   next_no;
    logic        order_err;
    logic        timeout;

    modport master (
        input  req_s, no_s, req_v, no_v, commit_ack,
        output grant_s, grant_v, commit_valid, commit_no, commit_src, next_no, order_err, timeout
    );

    modport slave (
        output req_s, no_s, req_v, no_v, commit_ack,
        input  grant_s, grant_v, commit_valid, commit_no, commit_src, next_no, order_err, timeout
    );

endinterface

// File: rtl/commit_watchdog.sv
// Retirement watchdog: counts cycles with a pending but non-matching request; sticky flag.
module commit_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clock,
    input  logic reset,
    input  logic pending_i,
    input  logic match_i,
    input  logic grant_i,
    output logic timeout_o
);
    localparam int unsigned CntW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(TIMEOUT_CYCLES - 1);

    logic [CntW-1:0] cnt_q, cnt_d;
    logic            flag_q, flag_d;

    always_comb begin
        cnt_d  = cnt_q;
        flag_d = flag_q | (cnt_q == CntMax);
        if (grant_i || !pending_i) begin
            cnt_d = '0;
        end else if (!match_i && cnt_q != CntMax) begin
            cnt_d = cnt_q + CntW'(1);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q  <= '0;
            flag_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            flag_q <= flag_d;
        end
    end

    assign timeout_o = flag_q;

endmodule

// File: rtl/commit_arbiter.sv
// Grants one commit per cycle from the scalar/vector reorder buffers in strict issue order.
module commit_arbiter
    import commit_arbiter_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input logic              clock,
    input logic              reset,
    commit_arbiter_if.master arb_io
);
    issue_no_t      next_no_q, next_no_d;
    logic           valid_q, valid_d;
    commit_entry_t  out_q, out_d;
    commit_arb_st_t state_q, state_d;
    logic           order_err_q, order_err_d;

    logic match_s, match_v, slot_free, grant_en, grant_s, grant_v, granted, pending;
    logic timeout;

    always_comb begin
        match_s   = arb_io.req_s & (arb_io.no_s == next_no_q);
        match_v   = arb_io.req_v & (arb_io.no_v == next_no_q);
        slot_free = ~valid_q | arb_io.commit_ack;
        // Grants drop combinationally while reset is high.
        grant_en  = slot_free & (state_q != ERR) & ~reset;
        grant_s   = grant_en & match_s & ~match_v;
        grant_v   = grant_en & match_v & ~match_s;
        granted   = grant_s | grant_v;
        pending   = arb_io.req_s | arb_io.req_v;
    end

    always_comb begin
        next_no_d   = next_no_q;
        valid_d     = valid_q;
        out_d       = out_q;
        state_d     = state_q;
        order_err_d = order_err_q | (match_s & match_v);

        if (granted) begin
            valid_d   = 1'b1;
            out_d.no  = next_no_q;
            out_d.src = grant_v ? COMMIT_VECTOR : COMMIT_SCALAR;
            next_no_d = next_no_q + issue_no_t'(1);
        end else if (arb_io.commit_ack) begin
            valid_d = 1'b0;
        end

        case (state_q)
            RUN: begin
                if (match_s && match_v) begin
                    state_d = ERR;
                end else if (valid_q && !arb_io.commit_ack) begin
                    state_d = HOLD;
                end
            end
            HOLD: begin
                if (match_s && match_v) begin
                    state_d = ERR;
                end else if (arb_io.commit_ack) begin
                    state_d = RUN;
                end
            end
            ERR:     state_d = ERR;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            next_no_q   <= '0;
            valid_q     <= 1'b0;
            out_q       <= '0;
            state_q     <= RUN;
            order_err_q <= 1'b0;
        end else begin
            next_no_q   <= next_no_d;
            valid_q     <= valid_d;
            out_q       <= out_d;
            state_q     <= state_d;
            order_err_q <= order_err_d;
        end
    end

    commit_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clock    (clock),
        .reset    (reset),
        .pending_i(pending),
        .match_i  (match_s | match_v),
        .grant_i  (granted),
        .timeout_o(timeout)
    );

    assign arb_io.grant_s      = grant_s;
    assign arb_io.grant_v      = grant_v;
    assign arb_io.commit_valid = valid_q;
    assign arb_io.commit_no    = out_q.no;
    assign arb_io.commit_src   = out_q.src;
    assign arb_io.next_no      = next_no_q;
    assign arb_io.order_err    = order_err_q;
    assign arb_io.timeout      = timeout;

endmodule

// File: tb/tb_commit_arbiter.sv
// Randomized and directed bench for commit_arbiter against an issue-order reference model.
module tb_commit_arbiter;
    import commit_arbiter_pkg::*;

    localparam int T = 8;

    logic clock = 1'b0;
    logic reset = 1'b1;

    commit_arbiter_if intf();

    commit_arbiter #(
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clock (clock),
        .reset (reset),
        .arb_io(intf.master)
    );

    always #5 clock = ~clock;

    int checks   = 0;
    int failures = 0;
    bit cmp_en   = 1'b0;

    // Reference model state
    int m_next  = 0;
    bit m_valid = 1'b0;
    int m_no    = 0;
    bit m_src   = 1'b0;
    bit m_err   = 1'b0;
    bit m_to    = 1'b0;
    int m_stall = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit model_match_s();
        return intf.req_s && (int'(intf.no_s) == m_next);
    endfunction

    function automatic bit model_match_v();
        return intf.req_v && (int'(intf.no_v) == m_next);
    endfunction

    // {grant_v, grant_s}
    function automatic logic [1:0] exp_grants();
        bit ms, mv, ok;
        ms = model_match_s();
        mv = model_match_v();
        ok = (!m_valid || intf.commit_ack) && !m_err && !reset;
        return {ok && mv && !ms, ok && ms && !mv};
    endfunction

    always @(posedge clock) begin : model
        logic [1:0] g;
        bit ms, mv, pend;
        g    = exp_grants();
        ms   = model_match_s();
        mv   = model_match_v();
        pend = intf.req_s || intf.req_v;
        if (reset) begin
            m_next  = 0;
            m_valid = 1'b0;
            m_no    = 0;
            m_src   = 1'b0;
            m_err   = 1'b0;
            m_to    = 1'b0;
            m_stall = 0;
        end else begin
            if (m_stall >= T - 1) m_to = 1'b1;
            if (pend && !(ms || mv)) m_stall++;
            else if (g != 2'b00 || !pend) m_stall = 0;
            if (g != 2'b00) begin
                m_valid = 1'b1;
                m_no    = m_next;
                m_src   = g[1];
                m_next  = (m_next + 1) % 256;
            end else if (intf.commit_ack) begin
                m_valid = 1'b0;
            end
            if (ms && mv) m_err = 1'b1;
        end
    end

    always @(negedge clock) begin : compare
        logic [1:0] g;
        if (cmp_en) begin
            g = exp_grants();
            check("grant_s", intf.grant_s, g[0]);
            check("grant_v", intf.grant_v, g[1]);
            check("commit_valid", intf.commit_valid, m_valid);
            check("commit_no", intf.commit_no, m_no);
            check("commit_src", intf.commit_src, m_src);
            check("next_no", intf.next_no, m_next);
            check("order_err", intf.order_err, m_err);
            check("timeout", intf.timeout, m_to);
        end
    end

    task automatic drive(input bit rs, input int ns, input bit rv, input int nv, input bit ack);
        intf.req_s      = rs;
        intf.no_s       = issue_no_t'(ns);
        intf.req_v      = rv;
        intf.no_v       = issue_no_t'(nv);
        intf.commit_ack = ack;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        drive(0, 0, 0, 0, 0);
        reset = 1'b1;
        step();
        step();
        reset  = 1'b0;
        cmp_en = 1'b1;
        #3;
        check("rst_valid", intf.commit_valid, 0);
        check("rst_next_no", intf.next_no, 0);
        check("rst_order_err", intf.order_err, 0);
        check("rst_timeout", intf.timeout, 0);

        // First scalar commit
        drive(1, 0, 0, 0, 1);
        #3 check("t1_grant_s", intf.grant_s, 1);
        step();
        drive(0, 0, 0, 0, 1);
        #3;
        check("t1_valid", intf.commit_valid, 1);
        check("t1_no", intf.commit_no, 0);
        check("t1_src", intf.commit_src, 0);
        check("t1_next_no", intf.next_no, 1);

        // Back-to-back interleaved commits
        drive(1, 1, 0, 0, 1); step();
        drive(0, 0, 1, 2, 1); step();
        drive(1, 3, 0, 0, 1); step();
        drive(0, 0, 0, 0, 1);
        #3;
        check("t2_no", intf.commit_no, 3);
        check("t2_next_no", intf.next_no, 4);

        // Vector ahead of order waits for the scalar
        drive(0, 0, 1, 5, 1);
        for (int i = 0; i < 3; i++) begin
            #3 check("t3_wait_grant_v", intf.grant_v, 0);
            step();
        end
        drive(1, 4, 1, 5, 1);
        #3 check("t3_grant_s", intf.grant_s, 1);
        step();
        drive(0, 0, 1, 5, 1);
        #3 check("t3_grant_v", intf.grant_v, 1);
        step();
        drive(0, 0, 0, 0, 1);
        step();

        // Output held unacked blocks a matching request
        drive(1, 6, 0, 0, 0); step();
        drive(0, 0, 1, 7, 0);
        for (int i = 0; i < 4; i++) begin
            #3 check("t4_hold_grant_v", intf.grant_v, 0);
            step();
        end
        drive(0, 0, 1, 7, 1);
        #3 check("t4_ack_grant_v", intf.grant_v, 1);
        step();
        drive(0, 0, 0, 0, 1);
        #3;
        check("t4_no", intf.commit_no, 7);
        check("t4_src", intf.commit_src, 1);
        step();

        // 256 sequential commits wrap the issue number
        for (int i = 0; i < 256; i++) begin
            if ($urandom_range(1) == 1) drive(1, m_next, 0, 0, 1);
            else drive(0, 0, 1, m_next, 1);
            step();
        end
        drive(0, 0, 0, 0, 1);
        #3 check("t5_next_no_wrap", intf.next_no, 8);
        step();

        // Randomized traffic
        for (int i = 0; i < 3000; i++) begin
            int sel, k1, k2;
            reset = ($urandom_range(99) < 2);
            sel = $urandom_range(3);
            k1  = $urandom_range(3);
            k2  = $urandom_range(3);
            case (sel)
                0: drive(1, m_next, $urandom_range(1), (m_next + 1 + k2) % 256,
                         $urandom_range(3) != 0);
                1: drive($urandom_range(1), (m_next + 1 + k1) % 256, 1, m_next,
                         $urandom_range(3) != 0);
                2: drive(1, (m_next + k1) % 256, 1, (m_next + k2) % 256,
                         $urandom_range(3) != 0);
                default: drive(0, 0, 0, 0, $urandom_range(3) != 0);
            endcase
            step();
        end
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        reset = 1'b0;

        // Duplicate issue number
        drive(1, 0, 1, 0, 1);
        #3;
        check("t6_dup_grant_s", intf.grant_s, 0);
        check("t6_dup_grant_v", intf.grant_v, 0);
        step();
        drive(1, 0, 0, 0, 1);
        #3;
        check("t6_order_err", intf.order_err, 1);
        check("t6_err_no_grant", intf.grant_s, 0);
        step();

        // Watchdog
        reset = 1'b1;
        drive(0, 0, 0, 0, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 1, 1, 1);
        for (int i = 0; i < 7; i++) step();
        #3 check("t7_timeout_early", intf.timeout, 0);
        step();
        #3 check("t7_timeout_rise", intf.timeout, 1);
        drive(1, 0, 1, 1, 1);
        #3 check("t7_commit_after_to", intf.grant_s, 1);
        step();
        drive(0, 0, 1, 1, 1);
        step();
        drive(0, 0, 0, 0, 1);
        #3 check("t7_timeout_sticky", intf.timeout, 1);
        step();

        // Reset while holding an unacked output
        drive(1, m_next, 0, 0, 0); step();
        drive(0, 0, 0, 0, 0); step();
        reset = 1'b1;
        drive(0, 0, 1, m_next, 1);
        #3 check("t8_grant_in_reset", intf.grant_v, 0);
        step();
        reset = 1'b0;
        drive(0, 0, 0, 0, 0);
        #3;
        check("t8_valid", intf.commit_valid, 0);
        check("t8_no", intf.commit_no, 0);
        check("t8_src", intf.commit_src, 0);
        check("t8_next_no", intf.next_no, 0);
        check("t8_timeout", intf.timeout, 0);
        step();

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
